// File: rtl/inst_mem_read_arbiter.sv
// inst_mem_read_arbiter: shares the single AXI read channel between NUM_REQ
// cache-side requesters (0 = dcache refill, 1 = uncached load, 2 = icache
// refill). One read transaction is outstanding at a time.
//
// Configuration macro: ARB_ROUND_ROBIN_EN
//   defined   -> round-robin arbitration starting after the last grant
//   undefined -> fixed priority, lowest index wins
//
// Handshake semantics: a transfer happens on any cycle where both valid and
// ready are high. arvalid is held with stable fields until arready. Response
// beats toward requesters have no back-pressure (resp_valid is a pure pulse).
module inst_mem_read_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ID_W    = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*32-1:0]  req_addr,
    input  logic [NUM_REQ*8-1:0]   req_len,
    input  logic [NUM_REQ*3-1:0]   req_size,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     resp_valid,
    output logic [31:0]            resp_data,
    output logic                   resp_last,
    output logic                   arvalid,
    output logic [31:0]            araddr,
    output logic [7:0]             arlen,
    output logic [2:0]             arsize,
    output logic [ID_W-1:0]        arid,
    input  logic                   arready,
    input  logic                   rvalid,
    input  logic [31:0]            rdata,
    input  logic                   rlast,
    input  logic [ID_W-1:0]        rid,
    output logic                   rready,
    output logic                   protocol_err,
    output logic [1:0]             dbg_state
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t          state;
    logic [GW-1:0]   grant;
    logic            win_found;
    logic [GW-1:0]   win_idx;
    logic [31:0]     win_addr;
    logic [7:0]      win_len;
    logic [2:0]      win_size;
    logic            beat_match;

`ifdef ARB_ROUND_ROBIN_EN
    logic [GW-1:0]   last_grant;
    int              cand;
`endif

    assign dbg_state  = state;
    assign beat_match = rvalid && (rid == arid);

    // Pick the winner from the current req_valid and mux out its fields.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_addr  = '0;
        win_len   = '0;
        win_size  = '0;
`ifdef ARB_ROUND_ROBIN_EN
        cand      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(last_grant) + 1 + k) % NUM_REQ;
            if (!win_found && req_valid[GW'(cand)]) begin
                win_found = 1'b1;
                win_idx   = GW'(cand);
            end
        end
`else
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[k]) begin
                win_found = 1'b1;
                win_idx   = GW'(k);
            end
        end
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win_idx == GW'(k)) begin
                win_addr = req_addr[32*k +: 32];
                win_len  = req_len[8*k +: 8];
                win_size = req_size[3*k +: 3];
            end
        end
    end

    // Accept pulse to the granted requester on the AR handshake cycle.
    always_comb begin
        req_ready = '0;
        if (state == S_ADDR && arvalid && arready) begin
            req_ready[grant] = 1'b1;
        end
    end

    // Zero-latency pass-through of matching R beats to the granted requester.
    always_comb begin
        resp_valid = '0;
        resp_data  = rdata;
        resp_last  = 1'b0;
        if (state == S_DATA && beat_match) begin
            resp_valid[grant] = 1'b1;
            resp_last         = rlast;
        end
    end

    // Main FSM with registered AR/R channel controls and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            grant        <= '0;
            arvalid      <= 1'b0;
            araddr       <= '0;
            arlen        <= '0;
            arsize       <= '0;
            arid         <= '0;
            rready       <= 1'b0;
            protocol_err <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant   <= GW'(NUM_REQ - 1);
`endif
        end else begin
            // A beat outside DATA, or with a foreign ID, is never forwarded.
            if (rvalid && (state != S_DATA || rid != arid)) begin
                protocol_err <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        grant   <= win_idx;
                        araddr  <= win_addr;
                        arlen   <= win_len;
                        arsize  <= win_size;
                        arid    <= ID_W'(win_idx);
                        arvalid <= 1'b1;
                        state   <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= S_DATA;
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant <= grant;
`endif
                    end
                end
                S_DATA: begin
                    if (beat_match && rlast) begin
                        rready <= 1'b0;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_mem_read_arbiter.sv
// Directed testbench for inst_mem_read_arbiter (NUM_REQ=3, ID_W=4).
// Builds with or without ARB_ROUND_ROBIN_EN; expectations follow the macro.
module tb_inst_mem_read_arbiter;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req_valid;
    logic [95:0] req_addr;
    logic [23:0] req_len;
    logic [8:0]  req_size;
    logic [2:0]  req_ready;
    logic [2:0]  resp_valid;
    logic [31:0] resp_data;
    logic        resp_last;
    logic        arvalid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [3:0]  arid;
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        rlast;
    logic [3:0]  rid;
    logic        rready;
    logic        protocol_err;
    logic [1:0]  dbg_state;

    int errors = 0;
    int checks = 0;
    logic [31:0] addr_tab [3];

    inst_mem_read_arbiter #(.NUM_REQ(3), .ID_W(4)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len),
        .req_size(req_size), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_last(resp_last),
        .arvalid(arvalid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arid(arid), .arready(arready),
        .rvalid(rvalid), .rdata(rdata), .rlast(rlast), .rid(rid),
        .rready(rready), .protocol_err(protocol_err), .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic set_req(input int p, input int len);
        req_valid[p]          = 1'b1;
        req_addr[32*p +: 32]  = addr_tab[p];
        req_len[8*p +: 8]     = 8'(len);
        req_size[3*p +: 3]    = 3'd2;
    endtask

    // Called on a negedge where the arbiter is IDLE with port p winning.
    task automatic run_txn(input int p, input int nb, input int ar_delay,
                           input logic [2:0] raise_mask, input int raise_at,
                           input bit bad_beat, input int abort_after);
        logic [2:0] onehot;
        bit aborted;
        onehot  = 3'(1 << p);
        aborted = 1'b0;
        @(negedge clk);
        chk("arvalid_latency", arvalid, 1);
        chk("arid", arid, p);
        chk("araddr", araddr, addr_tab[p]);
        chk("arlen", arlen, nb - 1);
        chk("arsize", arsize, 2);
        chk("state_addr", dbg_state, ST_ADDR);
        for (int i = 0; i < ar_delay; i++) begin
            chk("req_ready_wait", req_ready, 0);
            @(negedge clk);
            chk("arvalid_hold", arvalid, 1);
            chk("araddr_hold", araddr, addr_tab[p]);
            chk("arlen_hold", arlen, nb - 1);
        end
        arready = 1'b1;
        #1;
        chk("req_ready_pulse", req_ready, onehot);
        @(negedge clk);
        arready      = 1'b0;
        req_valid[p] = 1'b0;
        chk("rready_data", rready, 1);
        chk("req_ready_after", req_ready, 0);
        chk("state_data", dbg_state, ST_DATA);
        if (bad_beat) begin
            rvalid = 1'b1;
            rid    = (p == 1) ? 4'd2 : 4'd1;
            rdata  = 32'hDEAD_BEEF;
            rlast  = 1'b0;
            #1;
            chk("bad_beat_not_fwd", resp_valid, 0);
            @(negedge clk);
            rvalid = 1'b0;
            chk("protocol_err_set", protocol_err, 1);
        end
        for (int b = 0; b < nb; b++) begin
            if (abort_after != 0 && b == abort_after) begin
                aborted = 1'b1;
                break;
            end
            if (b == raise_at) req_valid = req_valid | raise_mask;
            rvalid = 1'b1;
            rid    = 4'(p);
            rdata  = 32'hD000_0000 | 32'(p << 8) | 32'(b);
            rlast  = (b == nb - 1);
            #1;
            chk("resp_valid", resp_valid, onehot);
            chk("resp_data", resp_data, 32'hD000_0000 | 32'(p << 8) | 32'(b));
            chk("resp_last", resp_last, (b == nb - 1));
            chk("no_preempt", req_ready, 0);
            @(negedge clk);
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        if (aborted) begin
            reset = 1'b1;
            @(negedge clk);
            chk("abort_arvalid", arvalid, 0);
            chk("abort_rready", rready, 0);
            chk("abort_state", dbg_state, ST_IDLE);
            reset     = 1'b0;
            req_valid = '0;
        end else begin
            chk("end_state_idle", dbg_state, ST_IDLE);
            chk("end_rready", rready, 0);
        end
    endtask

    initial begin
        addr_tab[0] = 32'h8000_1000;
        addr_tab[1] = 32'hA000_2000;
        addr_tab[2] = 32'hBFC0_0000;
        reset = 1'b1; req_valid = '0; req_addr = '0; req_len = '0; req_size = '0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rlast = 1'b0; rid = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_last", resp_last, 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_arlen", arlen, 0);
        chk("rst_arid", arid, 0);
        chk("rst_err", protocol_err, 0);
        chk("rst_state", dbg_state, ST_IDLE);
        reset = 1'b0;

        // 1: single icache refill, 4 beats
        set_req(2, 3);
        run_txn(2, 4, 0, 3'b000, -1, 1'b0, 0);

        // 2: all three request at once -> 0,1,2
        set_req(0, 1); set_req(1, 1); set_req(2, 1);
        run_txn(0, 2, 0, 3'b000, -1, 1'b0, 0);
        run_txn(1, 2, 0, 3'b000, -1, 1'b0, 0);
        run_txn(2, 2, 0, 3'b000, -1, 1'b0, 0);

        // 2b: persistent port 0 plus port 2
        set_req(0, 1); set_req(2, 1);
`ifdef ARB_ROUND_ROBIN_EN
        run_txn(0, 2, 0, 3'b001, 0, 1'b0, 0);
        run_txn(2, 2, 0, 3'b000, -1, 1'b0, 0);
        run_txn(0, 2, 0, 3'b000, -1, 1'b0, 0);
`else
        run_txn(0, 2, 0, 3'b001, 0, 1'b0, 0);
        run_txn(0, 2, 0, 3'b000, -1, 1'b0, 0);
        run_txn(2, 2, 0, 3'b000, -1, 1'b0, 0);
`endif

        // 3: arready held low for 5 cycles
        set_req(1, 0);
        run_txn(1, 1, 5, 3'b000, -1, 1'b0, 0);

        // 4: port 0 raises during port 2 burst, granted after the idle cycle
        set_req(2, 3);
        req_valid[0] = 1'b0;
        run_txn(2, 4, 0, 3'b001, 1, 1'b0, 0);
        run_txn(0, 2, 0, 3'b000, -1, 1'b0, 0);

        // New request coincident with rlast
        set_req(2, 1);
        req_valid[2] = 1'b0;
        set_req(1, 0);
        run_txn(1, 1, 0, 3'b100, 0, 1'b0, 0);
        run_txn(2, 2, 0, 3'b000, -1, 1'b0, 0);

        // 5: foreign rid while granted 2
        set_req(2, 1);
        run_txn(2, 2, 0, 3'b000, -1, 1'b1, 0);
        @(negedge clk);
        chk("protocol_err_sticky", protocol_err, 1);

        // 6: reset after beat 2 of 4, then a normal grant
        set_req(2, 3);
        run_txn(2, 4, 0, 3'b000, -1, 1'b0, 2);
        chk("err_cleared_by_reset", protocol_err, 0);
        set_req(1, 1);
        run_txn(1, 2, 0, 3'b000, -1, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_mem_read_arbiter.md
Name: inst_mem_read_arbiter

Overview:
- Shares the core's single AXI read channel between NUM_REQ cache-side requesters: port 0 = dcache refill, port 1 = uncached load, port 2 = icache refill (the ICache miss path behind the pre-fetch/fetch stages).
- One read transaction is outstanding at a time.
- Grants one requester, drives AR, then routes R beats back to the winner until rlast.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ID_W, 4, AXI ID width; arid = grant index zero-extended.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester read request
- req_addr  in  NUM_REQ*32  per-requester address; slice i = bits [32*i+31:32*i]
- req_len  in  NUM_REQ*8  per-requester AXI arlen (beats-1)
- req_size  in  NUM_REQ*3  per-requester AXI arsize
- req_ready  out  NUM_REQ  one-hot pulse; request accepted on the AR handshake cycle
- resp_valid  out  NUM_REQ  one-hot; data beat for the granted requester
- resp_data  out  32  beat data, broadcast to all requesters
- resp_last  out  1  final beat, broadcast
- arvalid  out  1  AXI AR valid
- araddr  out  32  AXI AR address
- arlen  out  8  AXI AR length
- arsize  out  3  AXI AR size
- arid  out  ID_W  AXI AR ID
- arready  in  1  AXI AR ready
- rvalid  in  1  AXI R valid
- rdata  in  32  AXI R data
- rlast  in  1  AXI R last
- rid  in  ID_W  AXI R ID
- rready  out  1  AXI R ready
- protocol_err  out  1  sticky error flag

Behaviour:
- FSM states:
  - IDLE: if any req_valid, pick the winner, latch grant index plus its addr/len/size into registers, go to ADDR. Arbitration is combinational on the IDLE-cycle req_valid.
  - ADDR: arvalid=1 with the latched fields. arvalid is held and fields are stable until arready. On arvalid&&arready: req_ready[grant]=1 for that cycle only, go to DATA.
  - DATA: rready=1. On rvalid with rid==grant: resp_valid[grant]=1, resp_data=rdata, resp_last=rlast, combinational pass-through with 0 added latency. On rvalid&&rlast&&rid match, go to IDLE.
- Minimum latency:
  - request seen in IDLE to arvalid: 1 cycle.
  - rlast to next arbitration: 1 idle cycle (re-arbitration happens in IDLE).
- Requesters:
  - Must hold req_valid and fields stable until req_ready.
  - A requester that drops req_valid before grant is legal only while the arbiter is in IDLE. Fields latched in ADDR are used regardless.
  - Every resp beat is accepted unconditionally by requesters; there is no back-pressure toward requesters.
- rvalid while in IDLE or ADDR, or rid != grant in DATA: beat is consumed (rready=1 in DATA only), not forwarded, and protocol_err is set. protocol_err clears only on reset.
- req_valid rising for another port during ADDR or DATA: ignored until the next IDLE. No preemption, even by higher priority.
- Simultaneous rlast and a new request: request is arbitrated in the following IDLE cycle.
- Reset values: state=IDLE, arvalid=0, rready=0, req_ready=0, resp_valid=0, resp_last=0, araddr/arlen/arsize/arid=0, protocol_err=0, round-robin pointer=NUM_REQ-1.
- Reset mid-burst: FSM returns to IDLE immediately and the burst is abandoned. The interconnect is reset by the same reset.
- Pipeline flush (exception/eret) is not seen by the arbiter. A cancelled icache refill still completes its burst, and the icache discards it.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN
- Defined:
  - Round-robin. Search starts at (last_grant+1) mod NUM_REQ.
  - last_grant updates on the AR handshake.
  - Any continuously requesting port is granted within NUM_REQ transactions.
- Undefined:
  - Fixed priority, lowest index wins (dcache > uncached > icache).
  - No last_grant register.

Test Plan:
1. Single icache request, addr 0xbfc00000, len 3, arready on 1st ADDR cycle, 4 R beats rid=2 -> arvalid one cycle after request, arid=2, req_ready[2] pulses once, resp_valid[2] on 4 beats, resp_last on 4th, IDLE next cycle.
2. req_valid=3'b111 simultaneously, fixed priority -> grants in order 0,1,2 across three bursts. With ARB_ROUND_ROBIN_EN after reset -> order 0,1,2 again. Then a persistent port 0 request plus a port 2 request -> ports 2 and 0 alternate.
3. arready held low 5 cycles -> arvalid/araddr/arlen stable all 5 cycles, req_ready only on the handshake cycle.
4. Port 0 requests during a port 2 DATA burst -> no preemption; port 0 granted after port 2's rlast plus 1 idle cycle.
5. R beat with rid=1 while granted 2 -> not forwarded, protocol_err=1 and stays 1 until reset.
6. Reset asserted mid-burst after beat 2 of 4 -> next cycle arvalid=0, rready=0, state IDLE. A new request is granted normally after reset.
